// File: rtl/cic_pkg.sv
// cic_pkg: shared state encoding and CIC constants for the CIC feed scheduler.
//   CIC_WIN     - CIC input sample width
//   CIC_WG      - CIC internal growth width (full precision)
//   FLUSH_N_DEF - zero samples needed to drain 3 comb + 3 integrator stages
//   state_t     - scheduler FSM states built on the S_* encodings
package cic_pkg;

    localparam int CIC_WIN     = 16;
    localparam int CIC_WG      = 22;
    localparam int FLUSH_N_DEF = 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        RUN   = S_RUN,
        FLUSH = S_FLUSH
    } state_t;

endpackage

// File: rtl/cic_slot_timer.sv
// cic_slot_timer: latches the slot period and generates one fire per period.
//   clk     - clock, rising edge
//   rst     - synchronous active-low reset
//   i_clr   - hold counter at 0 and (re)load the rate latch from i_rate
//   i_run   - count slots
//   i_rate  - requested slot period; 0 and 1 are clamped to 2
//   o_fire  - slot fires this cycle (counter at 0 while running)
module cic_slot_timer
    import cic_pkg::*;
#(
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_run,
    input  logic [RATE_W-1:0] i_rate,
    output logic              o_fire
);

    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] rate_c;
    logic [RATE_W-1:0] slot_cnt;

    // Periods below 2 would fire every cycle or never wrap; force them to 2.
    assign rate_c = (i_rate[RATE_W-1:1] == '0) ? RATE_W'(2) : i_rate;

    // Loading the latch on every clr cycle makes the value seen on the
    // IDLE->RUN edge the one that sticks for the whole run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rate_q   <= RATE_W'(2);
            slot_cnt <= '0;
        end else if (i_clr) begin
            rate_q   <= rate_c;
            slot_cnt <= '0;
        end else if (i_run) begin
            slot_cnt <= (slot_cnt == rate_q - 1'b1) ? '0 : slot_cnt + 1'b1;
        end
    end

    assign o_fire = i_run & ~i_clr & (slot_cnt == '0);

endmodule

// File: rtl/cic_feed_sched.sv
// cic_feed_sched: paces upstream samples into an interpolating CIC, one val_in
// strobe per slot, inserting zeros on underrun and draining the filter on flush.
//   clk        - clock, rising edge
//   rst        - synchronous active-low reset
//   i_enable   - run the schedule
//   i_flush    - 1-cycle drain request, honoured in RUN only
//   i_rate     - slot period, latched on IDLE->RUN
//   s_data     - upstream signed sample
//   s_valid    - upstream sample valid
//   s_ready    - sample accepted this cycle when s_valid is high
//   o_cic_data - registered sample to the CIC, held between strobes
//   o_cic_val  - registered 1-cycle strobe to the CIC
//   o_underrun - strobe carried an inserted zero while running
//   o_busy     - RUN or FLUSH
//   o_done     - 1-cycle pulse when a flush completes
module cic_feed_sched
    import cic_pkg::*;
#(
    parameter int Win     = CIC_WIN,
    parameter int RATE_W  = 8,
    parameter int FLUSH_N = FLUSH_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic              i_flush,
    input  logic [RATE_W-1:0] i_rate,
    input  logic [Win-1:0]    s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [Win-1:0]    o_cic_data,
    output logic              o_cic_val,
    output logic              o_underrun,
    output logic              o_busy,
    output logic              o_done
);

    localparam int FC_W = $clog2(FLUSH_N + 1);

    state_t            state;
    state_t            state_n;
    logic [FC_W-1:0]   flush_cnt;
    logic [FC_W-1:0]   flush_cnt_n;
    logic              done_n;
    logic              full;
    logic [Win-1:0]    buf_q;
    logic              fire;
    logic              take;
    logic              load;

    cic_slot_timer #(.RATE_W(RATE_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (state == IDLE),
        .i_run  (state != IDLE),
        .i_rate (i_rate),
        .o_fire (fire)
    );

    assign take = fire & full;

    // A take frees the single entry in the same cycle, so a refill needs no
    // bubble. FLUSH refuses new samples so the zero drain can finish.
    assign s_ready = rst & (state != FLUSH) & (~full | take);
    assign load    = s_valid & s_ready;
    assign o_busy  = (state != IDLE);

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) state_n = RUN;
            end
            RUN: begin
                if (!i_enable) begin
                    state_n = IDLE;
                end else if (i_flush) begin
                    state_n     = FLUSH;
                    flush_cnt_n = FC_W'(FLUSH_N);
                end
            end
            FLUSH: begin
                // Only zero slots count toward the drain; a buffered sample
                // goes out first without consuming one.
                if (fire && !full) begin
                    flush_cnt_n = flush_cnt - 1'b1;
                    if (flush_cnt == FC_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            full       <= 1'b0;
            buf_q      <= '0;
            o_cic_data <= '0;
            o_cic_val  <= 1'b0;
            o_underrun <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_n;
            flush_cnt  <= flush_cnt_n;
            o_done     <= done_n;
            o_cic_val  <= fire;
            o_underrun <= fire & ~full & (state == RUN);
            if (load) begin
                full  <= 1'b1;
                buf_q <= s_data;
            end else if (take) begin
                full <= 1'b0;
            end
            if (fire) o_cic_data <= full ? buf_q : '0;
        end
    end

endmodule

// File: tb/tb_cic_feed_sched.sv
// tb_cic_feed_sched: self-checking bench for cic_feed_sched.
module tb_cic_feed_sched;

    localparam int W  = 16;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_enable = 1'b0;
    logic          i_flush = 1'b0;
    logic [RW-1:0] i_rate = '0;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  o_cic_data;
    logic          o_cic_val;
    logic          o_underrun;
    logic          o_busy;
    logic          o_done;

    always #5 clk = ~clk;

    cic_feed_sched dut (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (i_enable),
        .i_flush    (i_flush),
        .i_rate     (i_rate),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .o_cic_data (o_cic_data),
        .o_cic_val  (o_cic_val),
        .o_underrun (o_underrun),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
        logic         unr;
    } exp_t;

    typedef struct {
        logic [RW-1:0] rate;
        int            per;
    } rate_vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nstrobe = 0;
    int   acc = 0;
    bit   src_on = 1'b0;
    bit   sb_push = 1'b0;
    bit   skip_unr = 1'b0;
    bit   hs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void exp_push(int c, logic [W-1:0] d, logic u);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        e.unr  = u;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (o_underrun) chk("underrun_only_with_strobe", o_cic_val, 1);
        if (o_cic_val && !(skip_unr && o_underrun)) begin
            nstrobe++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_strobe: got data %0h at cyc %0d expected no strobe", o_cic_data, cyc);
            end else begin
                e = q.pop_front();
                chk("strobe_data", o_cic_data, e.data);
                chk("strobe_underrun", o_underrun, e.unr);
                if (e.cyc >= 0) chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic src_sample();
        hs = s_valid & s_ready;
        if (hs) acc++;
        if (hs && sb_push) exp_push(-1, s_data, 1'b0);
    endtask

    task automatic src_off();
        s_valid = 1'b0;
        if (hs) begin
            hs = 1'b0;
            acc--;
            if (sb_push) void'(q.pop_back());
        end
        src_on = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (src_on) begin
                if (hs) s_data = s_data + 1'b1;
                src_sample();
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        i_enable = 1'b0;
        i_flush = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        src_on = 1'b0;
        sb_push = 1'b0;
        skip_unr = 1'b0;
        hs = 1'b0;
        @(negedge clk);
        chk("rst_val", o_cic_val, 0);
        chk("rst_data", o_cic_data, 0);
        chk("rst_underrun", o_underrun, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ready", s_ready, 0);
        rst = 1'b1;
        #1;
        chk("idle_ready", s_ready, 1);
    endtask

    task automatic stream_run();
        int e;
        i_rate = 8'd4;
        s_data = 16'd1;
        s_valid = 1'b1;
        i_enable = 1'b1;
        src_on = 1'b1;
        src_sample();
        e = cyc + 1;
        for (int n = 0; n < 5; n++) exp_push(e + 1 + 4 * n, W'(n + 1), 1'b0);
        step(18);
        i_enable = 1'b0;
        src_off();
        step(6);
        chk("stream_drained", q.size(), 0);
        chk("stream_busy_off", o_busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rate_vec_t tv[5];
        int e;
        int s0;
        tv[0] = '{8'd0, 2};
        tv[1] = '{8'd1, 2};
        tv[2] = '{8'd3, 3};
        tv[3] = '{8'd9, 9};
        tv[4] = '{8'd255, 255};

        // steady stream
        do_reset();
        stream_run();

        // underrun
        do_reset();
        i_rate = 8'd3;
        s_data = 16'h7FFF;
        s_valid = 1'b1;
        i_enable = 1'b1;
        e = cyc + 1;
        exp_push(e + 1, 16'h7FFF, 1'b0);
        exp_push(e + 4, 16'h0000, 1'b1);
        exp_push(e + 7, 16'h0000, 1'b1);
        step(1);
        s_valid = 1'b0;
        step(7);
        i_enable = 1'b0;
        step(2);
        chk("underrun_drained", q.size(), 0);

        // flush with a buffered sample
        do_reset();
        i_rate = 8'd2;
        i_enable = 1'b1;
        e = cyc + 1;
        exp_push(e + 1, 16'h0000, 1'b1);
        exp_push(e + 3, 16'hFFFB, 1'b0);
        for (int k = 0; k < 6; k++) exp_push(e + 5 + 2 * k, 16'h0000, 1'b0);
        step(2);
        s_data = 16'hFFFB;
        s_valid = 1'b1;
        i_flush = 1'b1;
        step(1);
        s_valid = 1'b0;
        i_flush = 1'b0;
        chk("flush_busy", o_busy, 1);
        step(1);
        chk("flush_ready_low", s_ready, 0);
        step(1);
        i_enable = 1'b0;
        step(10);
        chk("flush_busy_before_done", o_busy, 1);
        chk("flush_no_early_done", o_done, 0);
        step(1);
        chk("flush_done", o_done, 1);
        chk("flush_busy_falls", o_busy, 0);
        step(1);
        chk("flush_done_one_cycle", o_done, 0);
        chk("flush_drained", q.size(), 0);

        // disable beats flush in the same cycle
        i_rate = 8'd2;
        i_enable = 1'b1;
        e = cyc + 1;
        exp_push(e + 1, 16'h0000, 1'b1);
        step(1);
        i_enable = 1'b0;
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        chk("disable_wins_busy", o_busy, 0);
        step(1);
        chk("disable_wins_no_done", o_done, 0);
        step(3);
        chk("disable_wins_drained", q.size(), 0);

        // rate clamp and latch, table driven
        do_reset();
        for (int t = 0; t < 5; t++) begin
            i_rate = tv[t].rate;
            i_enable = 1'b1;
            e = cyc + 1;
            for (int n = 0; n < 3; n++) exp_push(e + 1 + tv[t].per * n, 16'h0000, 1'b1);
            step(1);
            i_rate = 8'd9;
            step(2 * tv[t].per + 1);
            i_enable = 1'b0;
            step(2);
            chk("rate_strobes_seen", q.size(), 0);
        end
        i_enable = 1'b1;
        e = cyc + 1;
        exp_push(e + 1, 16'h0000, 1'b1);
        exp_push(e + 10, 16'h0000, 1'b1);
        step(11);
        i_enable = 1'b0;
        step(2);
        chk("rate_relatch_drained", q.size(), 0);

        // reset mid-flush at flush_cnt = 3
        do_reset();
        i_rate = 8'd2;
        i_enable = 1'b1;
        e = cyc + 1;
        exp_push(e + 1, 16'h0000, 1'b1);
        exp_push(e + 3, 16'h0000, 1'b0);
        exp_push(e + 5, 16'h0000, 1'b0);
        exp_push(e + 7, 16'h0000, 1'b0);
        step(2);
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        step(4);
        do_reset();
        step(3);
        chk("no_done_after_reset", o_done, 0);
        chk("reset_flush_drained", q.size(), 0);
        stream_run();

        // back-to-back handshake against a reference queue
        do_reset();
        skip_unr = 1'b1;
        sb_push = 1'b1;
        i_rate = 8'd2;
        s_data = 16'd100;
        s_valid = 1'b1;
        i_enable = 1'b1;
        src_on = 1'b1;
        acc = 0;
        s0 = nstrobe;
        src_sample();
        step(40);
        src_off();
        step(4);
        i_enable = 1'b0;
        step(2);
        chk("b2b_accepted", acc, 21);
        chk("b2b_strobes", nstrobe - s0, 21);
        chk("b2b_drained", q.size(), 0);
        skip_unr = 1'b0;
        sb_push = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
